// File: rtl/efuse_ctrl.sv
// Read/program sequencer for a 32-bit eFuse macro: setup, strobe and hold timing for the macro.
// Optional EFUSE_PGM_VERIFY_EN adds a margin-read verify pass after programming.
module efuse_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_RD    = 4,
  parameter int unsigned T_PGM   = 100,
  parameter int unsigned T_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic        margin_read,
  input  logic [31:0] data_write,
  output logic        rd_done,
  output logic        wr_done,
  output logic [31:0] data_read,
  output logic        pgm_err,
  output logic        efuse_csb,
  output logic        efuse_rden,
  output logic        efuse_pgmen,
  output logic        efuse_strobe,
  output logic        efuse_mr,
  output logic [4:0]  efuse_addr,
  input  logic [31:0] efuse_dout
);

  localparam logic [15:0] LP_SETUP = 16'(T_SETUP);
  localparam logic [15:0] LP_RD    = 16'(T_RD);
  localparam logic [15:0] LP_PGM   = 16'(T_PGM);
  localparam logic [15:0] LP_HOLD  = 16'(T_HOLD);

  typedef enum logic [3:0] {
    StIdle, StRdSetup, StRdStrobe, StRdHold, StRdDone,
    StPgScan, StPgSetup, StPgStrobe, StPgHold, StWrDone
  } state_e;

  state_e      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_wbuf;
  logic [4:0]  r_bit_idx;
  logic        r_verify;

  logic w_cnt_end;
  logic w_last_bit;
  assign w_cnt_end  = (r_cnt == 16'd1);
  assign w_last_bit = (r_bit_idx == 5'd31);

`ifndef EFUSE_PGM_VERIFY_EN
  assign pgm_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= 16'd0;
      r_wbuf       <= 32'd0;
      r_bit_idx    <= 5'd0;
      r_verify     <= 1'b0;
      rd_done      <= 1'b0;
      wr_done      <= 1'b0;
      data_read    <= 32'd0;
      efuse_csb    <= 1'b1;
      efuse_rden   <= 1'b0;
      efuse_pgmen  <= 1'b0;
      efuse_strobe <= 1'b0;
      efuse_mr     <= 1'b0;
      efuse_addr   <= 5'd0;
`ifdef EFUSE_PGM_VERIFY_EN
      pgm_err      <= 1'b0;
`endif
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (write || read) begin
            r_wbuf    <= data_write;
            efuse_mr  <= margin_read;
            r_bit_idx <= 5'd0;
            r_verify  <= 1'b0;
          end
          if (write) begin
            r_state <= StPgScan;
`ifdef EFUSE_PGM_VERIFY_EN
            pgm_err <= 1'b0;
`endif
          end else if (read) begin
            r_state    <= StRdSetup;
            r_cnt      <= LP_SETUP;
            efuse_csb  <= 1'b0;
            efuse_rden <= 1'b1;
          end
        end
        StRdSetup: begin
          if (w_cnt_end) begin
            r_state      <= StRdStrobe;
            r_cnt        <= LP_RD;
            efuse_strobe <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StRdStrobe: begin
          if (w_cnt_end) begin
            r_state      <= StRdHold;
            r_cnt        <= LP_HOLD;
            efuse_strobe <= 1'b0;
            data_read    <= efuse_dout;
`ifdef EFUSE_PGM_VERIFY_EN
            // Only blown bits matter; extra 1s in the array are not a failure
            if (r_verify) pgm_err <= ((efuse_dout & r_wbuf) != r_wbuf);
`endif
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StRdHold: begin
          if (w_cnt_end) begin
            efuse_csb  <= 1'b1;
            efuse_rden <= 1'b0;
            efuse_mr   <= 1'b0;
            r_verify   <= 1'b0;
            if (r_verify) begin
              r_state <= StWrDone;
              wr_done <= 1'b1;
            end else begin
              r_state <= StRdDone;
              rd_done <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StRdDone: r_state <= StIdle;
        StPgScan: begin
          if (r_wbuf[r_bit_idx]) begin
            r_state     <= StPgSetup;
            r_cnt       <= LP_SETUP;
            efuse_addr  <= r_bit_idx;
            efuse_csb   <= 1'b0;
            efuse_pgmen <= 1'b1;
          end else if (w_last_bit) begin
`ifdef EFUSE_PGM_VERIFY_EN
            r_state    <= StRdSetup;
            r_cnt      <= LP_SETUP;
            r_verify   <= 1'b1;
            efuse_csb  <= 1'b0;
            efuse_rden <= 1'b1;
            efuse_mr   <= 1'b1;
`else
            r_state <= StWrDone;
            wr_done <= 1'b1;
`endif
          end else begin
            r_bit_idx <= r_bit_idx + 5'd1;
          end
        end
        StPgSetup: begin
          if (w_cnt_end) begin
            r_state      <= StPgStrobe;
            r_cnt        <= LP_PGM;
            efuse_strobe <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StPgStrobe: begin
          if (w_cnt_end) begin
            r_state      <= StPgHold;
            r_cnt        <= LP_HOLD;
            efuse_strobe <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StPgHold: begin
          if (w_cnt_end) begin
            efuse_csb   <= 1'b1;
            efuse_pgmen <= 1'b0;
            if (w_last_bit) begin
`ifdef EFUSE_PGM_VERIFY_EN
              r_state    <= StRdSetup;
              r_cnt      <= LP_SETUP;
              r_verify   <= 1'b1;
              efuse_csb  <= 1'b0;
              efuse_rden <= 1'b1;
              efuse_mr   <= 1'b1;
`else
              r_state <= StWrDone;
              wr_done <= 1'b1;
`endif
            end else begin
              r_state   <= StPgScan;
              r_bit_idx <= r_bit_idx + 5'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StWrDone: begin
          r_state  <= StIdle;
          efuse_mr <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_ctrl.sv
// Self-checking bench for efuse_ctrl: directed and random reads/programs against a
// latency/strobe model derived from bit counts and phase lengths.
module tb_efuse_ctrl;

  localparam int S     = 2;
  localparam int R     = 4;
  localparam int P     = 100;
  localparam int H     = 2;
  localparam int LIMIT = 4000;
`ifdef EFUSE_PGM_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write, margin_read;
  logic [31:0] data_write, efuse_dout;
  logic        rd_done, wr_done, pgm_err;
  logic [31:0] data_read;
  logic        efuse_csb, efuse_rden, efuse_pgmen, efuse_strobe, efuse_mr;
  logic [4:0]  efuse_addr;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_data_read;
  logic        exp_err;

  always #5 clk = ~clk;

  efuse_ctrl #(.T_SETUP(S), .T_RD(R), .T_PGM(P), .T_HOLD(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .read         (read),
    .write        (write),
    .margin_read  (margin_read),
    .data_write   (data_write),
    .rd_done      (rd_done),
    .wr_done      (wr_done),
    .data_read    (data_read),
    .pgm_err      (pgm_err),
    .efuse_csb    (efuse_csb),
    .efuse_rden   (efuse_rden),
    .efuse_pgmen  (efuse_pgmen),
    .efuse_strobe (efuse_strobe),
    .efuse_mr     (efuse_mr),
    .efuse_addr   (efuse_addr),
    .efuse_dout   (efuse_dout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issues one request from IDLE, watches the macro pins until the done pulse, then checks.
  task automatic run_op(input bit is_wr, input bit both, input bit mr,
                        input logic [31:0] wdata, input logic [31:0] dout);
    int n, done_n, rd_cnt, wr_cnt, excl, stray, csb_low, addr_chg, mr_bad, strobe_w;
    int exp_lat, exp_csb;
    int pg_w[$];
    int pg_a[$];
    int rd_w[$];
    int exp_idx[$];
    bit prev_strobe, prev_pgmen, pulse_pg, mr_at_done;
    logic [4:0] prev_addr;
    n = 0; done_n = 0; rd_cnt = 0; wr_cnt = 0; excl = 0; stray = 0; csb_low = 0;
    addr_chg = 0; mr_bad = 0; strobe_w = 0; prev_strobe = 0; prev_pgmen = 0; pulse_pg = 0;
    mr_at_done = 0; prev_addr = '0;
    for (int i = 0; i < 32; i++) if (wdata[i]) exp_idx.push_back(i);

    efuse_dout  = dout;
    data_write  = wdata;
    margin_read = mr;
    write       = is_wr;
    read        = !is_wr || both;
    @(posedge clk);
    #1;
    read        = 1'b0;
    write       = 1'b0;
    margin_read = 1'($urandom);
    data_write  = $urandom;

    for (n = 1; n <= LIMIT; n++) begin
      if (efuse_rden && efuse_pgmen) excl++;
      if (rd_done && wr_done) excl++;
      if (rd_done) rd_cnt++;
      if (wr_done) wr_cnt++;
      if (!efuse_csb) csb_low++;
      if (!is_wr && !efuse_csb && efuse_mr != mr) mr_bad++;
      if (!is_wr && efuse_pgmen) stray++;
      if (efuse_strobe && !efuse_pgmen && !efuse_rden) stray++;
      if (efuse_pgmen && prev_pgmen && efuse_addr != prev_addr) addr_chg++;
      if (efuse_strobe) begin
        if (!prev_strobe) begin
          strobe_w = 0;
          pulse_pg = efuse_pgmen;
          if (efuse_pgmen) pg_a.push_back(int'(efuse_addr));
        end
        strobe_w++;
      end else if (prev_strobe) begin
        if (pulse_pg) pg_w.push_back(strobe_w);
        else rd_w.push_back(strobe_w);
      end
      if ((rd_done || wr_done) && done_n == 0) begin
        done_n     = n;
        mr_at_done = efuse_mr;
      end
      prev_strobe = efuse_strobe;
      prev_pgmen  = efuse_pgmen;
      prev_addr   = efuse_addr;
      if (done_n != 0 && n >= done_n + 2) break;
      @(posedge clk);
      #1;
    end

    if (is_wr) begin
      exp_lat = 32 + exp_idx.size() * (S + P + H) + 1 + V * (S + R + H);
      exp_csb = exp_idx.size() * (S + P + H) + V * (S + R + H);
      if (V != 0) begin
        exp_data_read = dout;
        exp_err       = ((dout & wdata) != wdata);
      end else begin
        exp_err = 1'b0;
      end
    end else begin
      exp_lat       = 1 + S + R + H;
      exp_csb       = S + R + H;
      exp_data_read = dout;
    end

    check_eq("done_seen", 32'(done_n != 0), 32'd1);
    check_eq("latency", done_n, exp_lat);
    check_eq("rd_done_count", rd_cnt, is_wr ? 0 : 1);
    check_eq("wr_done_count", wr_cnt, is_wr ? 1 : 0);
    check_eq("exclusive", excl, 0);
    check_eq("stray_enable", stray, 0);
    check_eq("csb_low_cycles", csb_low, exp_csb);
    check_eq("idle_csb", efuse_csb, 1);
    check_eq("data_read", data_read, exp_data_read);
    check_eq("pgm_err", pgm_err, exp_err);
    if (is_wr) begin
      check_eq("pg_pulses", pg_w.size(), exp_idx.size());
      for (int i = 0; i < pg_w.size() && i < exp_idx.size(); i++) begin
        check_eq("pg_addr", pg_a[i], exp_idx[i]);
        check_eq("pg_width", pg_w[i], P);
      end
      check_eq("addr_stable", addr_chg, 0);
      check_eq("verify_pulses", rd_w.size(), V);
    end else begin
      check_eq("rd_pulses", rd_w.size(), 1);
      if (rd_w.size() > 0) check_eq("rd_width", rd_w[0], R);
      check_eq("mr_during_read", mr_bad, 0);
      check_eq("mr_after_read", mr_at_done, 0);
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] wd, dd;
    rst = 1'b1; read = 1'b0; write = 1'b0; margin_read = 1'b0;
    data_write = '0; efuse_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs", {rd_done, wr_done, pgm_err, efuse_rden, efuse_pgmen,
                          efuse_strobe, efuse_mr, efuse_addr}, 32'd0);
    check_eq("rst_csb", efuse_csb, 1);
    check_eq("rst_data", data_read, 32'd0);
    rst = 1'b0;
    exp_data_read = '0;
    exp_err       = 1'b0;
    @(posedge clk);
    #1;

    run_op(0, 0, 0, 32'h1234_5678, 32'hA5A5_0F0F);
    run_op(0, 0, 1, 32'h0, 32'h3C3C_C3C3);
    run_op(1, 0, 0, 32'h8000_0001, 32'h8000_0001);
    run_op(1, 0, 1, 32'h0, 32'hFFFF_0000);
    run_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Simultaneous requests: program first, read only after it is re-asserted
    run_op(1, 1, 0, 32'h0000_0410, 32'h0000_0410);
    cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rd_done) cnt++;
    end
    check_eq("no_stale_read", cnt, 0);
    run_op(0, 0, 0, 32'h0, 32'hDEAD_BEEF);

`ifdef EFUSE_PGM_VERIFY_EN
    run_op(1, 0, 0, 32'h0000_0110, 32'h0000_0100);
`endif

    for (int k = 0; k < 10; k++) begin
      dd = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        wd = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
        dd = ($urandom_range(0, 2) == 0) ? (wd & $urandom) : (wd | $urandom);
        run_op(1, 0, 1'($urandom), wd, dd);
      end else begin
        run_op(0, 0, 1'($urandom), $urandom, dd);
      end
    end

    // Reset in the middle of a program strobe
    data_write = 32'h8000_0001;
    write      = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    for (int i = 0; i < 20 && !efuse_strobe; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_reach_strobe", efuse_strobe, 1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("rst_async_strobe", efuse_strobe, 0);
    check_eq("rst_async_pgmen", efuse_pgmen, 0);
    check_eq("rst_async_rden", efuse_rden, 0);
    check_eq("rst_async_csb", efuse_csb, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (wr_done || rd_done || efuse_strobe || !efuse_csb) cnt++;
    end
    check_eq("rst_no_activity", cnt, 0);
    check_eq("rst_data_cleared", data_read, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/efuse_ctrl.md
# efuse_ctrl

Responder side of the read/program request interface driven by the main eFuse state machine. It accepts level `read`/`write` requests, sequences the 32-bit eFuse/EPROM macro through setup, strobe and hold phases, and returns one-cycle `rd_done`/`wr_done` pulses. Read results come back on `data_read`. The block sits between the main state machine and the hard macro and owns all macro timing.

## Interface
Parameters:
- `T_SETUP`, 2: cycles of address/enable setup before each strobe (1..65535).
- `T_RD`, 4: read strobe width in cycles (1..65535).
- `T_PGM`, 100: program strobe width per fuse bit in cycles (1..65535).
- `T_HOLD`, 2: cycles of hold after each strobe (1..65535).

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `read`  input  1  read request level.
- `write`  input  1  program request level.
- `margin_read`  input  1  selects margin-read mode for the read being accepted.
- `data_write`  input  32  bits to blow; 1 = program that bit.
- `rd_done`  output  1  one-cycle pulse when a read completes.
- `wr_done`  output  1  one-cycle pulse when a program completes.
- `data_read`  output  32  last word read from the macro.
- `pgm_err`  output  1  program-verify failure flag (see Configuration).
- `efuse_csb`  output  1  macro chip select, active low.
- `efuse_rden`  output  1  macro read enable.
- `efuse_pgmen`  output  1  macro program enable.
- `efuse_strobe`  output  1  macro strobe.
- `efuse_mr`  output  1  macro margin-read select.
- `efuse_addr`  output  5  bit index being programmed.
- `efuse_dout`  input  32  macro parallel read data.

## Operation
- Reset values: `efuse_csb`=1. All other outputs are 0, including `data_read`=0, `efuse_addr`=0 and `pgm_err`=0.
- All outputs are registered. The state is one of IDLE, RD_SETUP, RD_STROBE, RD_HOLD, RD_DONE, PG_SCAN, PG_SETUP, PG_STROBE, PG_HOLD, WR_DONE.
- IDLE samples the requests. `write` has priority over `read`. On accept, the block latches `data_write` into `wbuf` and `margin_read` into `efuse_mr`, and clears `bit_idx`.
- Read sequence:
  - `efuse_csb`=0 and `efuse_rden`=1 from RD_SETUP through RD_HOLD.
  - `efuse_strobe`=1 only in RD_STROBE.
  - `efuse_dout` is captured into `data_read` at the last RD_STROBE edge.
  - RD_DONE asserts `rd_done` for one cycle, then the block returns to IDLE.
- Program sequence:
  - PG_SCAN tests `wbuf[bit_idx]`, one cycle per bit.
  - A 0 bit is skipped: `bit_idx`+1.
  - A 1 bit enters PG_SETUP → PG_STROBE → PG_HOLD, driving `efuse_addr`=`bit_idx` with `efuse_csb`=0 and `efuse_pgmen`=1 throughout; `efuse_strobe`=1 only in PG_STROBE. The block then returns to PG_SCAN with `bit_idx`+1.
  - After `bit_idx`=31 is handled, the block enters WR_DONE, pulses `wr_done` once and returns to IDLE.
- `efuse_mr` is held for the whole read. It clears to 0 on return to IDLE.
- A single 16-bit down-counter times every phase. It is loaded with the phase length on entry, and the phase ends when the counter reaches 1.
- A request that drops mid-operation is ignored. The operation completes and the done pulse is still issued.
- The initiator drops its request on the edge following the done pulse. The single IDLE cycle after DONE therefore never re-accepts a stale request.
- `data_read` holds its value until the next read capture.
- `efuse_rden` and `efuse_pgmen` are never high in the same cycle.

## Timing
- Read: `rd_done` is high in cycle 1+`T_SETUP`+`T_RD`+`T_HOLD` after the accepting edge. With default parameters that is cycle 9.
- Program: latency is 32 scan cycles plus (`T_SETUP`+`T_PGM`+`T_HOLD`) per set bit, plus 1 cycle for WR_DONE.
  - `data_write`=0 gives `wr_done` 33 cycles after accept, with no strobe.
  - All ones gives 32+32×104+1 cycles with default parameters.
- The strobe is a clean level for exactly `T_RD` or `T_PGM` cycles. `efuse_addr` is stable for `T_SETUP` cycles before and `T_HOLD` cycles after each strobe.
- Reset mid-operation: `efuse_strobe`, `efuse_pgmen` and `efuse_rden` drop immediately and asynchronously, `efuse_csb` goes to 1, and the state goes to IDLE with no done pulse.
- At most one of `rd_done`/`wr_done` is high in any cycle.

## Configuration
- `EFUSE_PGM_VERIFY_EN` defined:
  - After the last bit, the block runs an internal read with `efuse_mr`=1, using the same RD_* phases, before WR_DONE.
  - `pgm_err` is set if (`efuse_dout` & `wbuf`) != `wbuf`. It is cleared at the next write accept.
  - `data_read` is updated with the verify word.
  - Program latency grows by `T_SETUP`+`T_RD`+`T_HOLD`.
  - `rd_done` is not pulsed during the verify read.
- `EFUSE_PGM_VERIFY_EN` undefined: `pgm_err` is tied to 0, and WR_DONE follows the scan directly.

## Test plan
- Read with defaults and `efuse_dout`=32'hA5A5_0F0F: `rd_done` high in cycle 9 after accept, `data_read`=32'hA5A5_0F0F, `efuse_strobe` high exactly 4 cycles, `efuse_mr`=0.
- Margin read (`margin_read`=1 at accept): `efuse_mr`=1 from RD_SETUP through RD_HOLD and 0 after.
- Program `data_write`=32'h8000_0001: exactly two strobes, at `efuse_addr`=0 and 31, each 100 cycles wide with `efuse_pgmen`=1; `wr_done` after 32+208+1 cycles.
- Program `data_write`=0: no strobe, `wr_done` 33 cycles after accept.
- `read` and `write` both high in IDLE: the program runs first, and the read is serviced only after `wr_done` and a re-assertion of `read`.
- Assert `rst` during PG_STROBE: strobe and `efuse_pgmen` are 0 immediately, `efuse_csb`=1, no `wr_done`; with `EFUSE_PGM_VERIFY_EN`, a separate case forces a stuck-0 bit and expects `pgm_err`=1.
